deflate_bit_packer: RTL
=======================

# deflate_bit_packer

Encoder-side bit packer for the DEFLATE datapath, the transmit-side counterpart of `decoder`. Accepts variable-length codes (Huffman codes, extra bits, block headers) one per cycle. Concatenates them LSB-first into a continuous bitstream and emits it as bytes over a valid/ready handshake. An explicit flush pads the final partial byte with zeros and signals completion, so the next stage can close the output file.

## Interface
- `MAX_CODE_LEN`, 16: widest code accepted, in bits.
- `ACC_W`, 32: bit accumulator width. Must satisfy `ACC_W >= 2*MAX_CODE_LEN`.
- `LEN_W`, 5: width of the length field.
- `clk`  in  1  single clock; all state updates on rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  code word present.
- `in_ready`  out  1  packer can accept a code this cycle.
- `in_code`  in  MAX_CODE_LEN  code bits; only bits [len-1:0] are used.
- `in_len`  in  LEN_W  number of valid bits, 0..MAX_CODE_LEN.
- `flush_req`  in  1  one-cycle request to pad and drain.
- `out_valid`  out  1  `out_byte` valid.
- `out_ready`  in  1  downstream accepts byte.
- `out_byte`  out  8  packed byte; bit 0 is the earliest bit in the stream.
- `flush_done`  out  1  one-cycle pulse when a flush completes.
- `err_len`  out  1  sticky flag: an accepted `in_len` exceeded MAX_CODE_LEN.
- `byte_count`  out  32  total bytes handed off since reset.

## Operation
- State: `acc[ACC_W-1:0]` and `fill` (0..ACC_W). FSM states are RUN, FLUSH, DONE.
- Input accept: `in_valid && in_ready`.
  - `in_ready = (state==RUN) && (fill <= ACC_W-MAX_CODE_LEN)`.
  - On accept, `acc |= (in_code & mask(in_len)) << fill_after_emit`.
- Output:
  - `out_valid = (fill >= 8) || (state==FLUSH && fill > 0)`.
  - `out_byte = acc[7:0]`. Bits above `fill` are always zero, so a padded byte has zeros in its upper bits.
- Emit: `out_valid && out_ready`. Shifts `acc` right by 8 and sets `fill -= min(8, fill)`.
- Simultaneous emit and accept in one cycle are legal. Update order: emit shift first, then insert the new code at the reduced `fill`.
- `in_len == 0`: the code is accepted as a no-op.
- `in_len > MAX_CODE_LEN`: the code is accepted, its length is clamped to MAX_CODE_LEN, and `err_len` is set until reset.
- FSM:
  - RUN → FLUSH on `flush_req`. If a code is accepted in the same cycle, it is included in the flush.
  - FLUSH → DONE in the cycle after `fill` reaches 0.
  - DONE → RUN after one cycle, with `flush_done=1` in DONE.
  - `flush_req` outside RUN is ignored.
  - FLUSH with `fill==0` on entry goes straight to DONE.
- `byte_count` increments on every emit and wraps modulo 2^32.

## Timing
- Reset values: `acc=0`, `fill=0`, state RUN, `out_valid=0`, `flush_done=0`, `err_len=0`, `byte_count=0`, `out_byte=0`. `in_ready` reads 1 once `fill=0` is in RUN.
- Assertion of `reset` mid-stream discards all buffered bits immediately. It also discards any flush in progress, with no `flush_done`.
- Latency: a code accepted at edge N can appear in `out_byte` from cycle N+1.
- Throughput: one code per cycle while `fill <= ACC_W-MAX_CODE_LEN`; output is one byte per cycle.
- Holding rules:
  - `out_byte` and `out_valid` must hold stable while `out_valid && !out_ready`.
  - `in_ready` never depends combinationally on `in_valid`.
- `flush_done` is asserted exactly one cycle, in the cycle after the last byte's handshake.

## Configuration
- `DEFLATE_BIT_PACKER_REVERSE_EN` defined:
  - `in_code[in_len-1:0]` is bit-reversed before insertion, so Huffman codes are given MSB-first as DEFLATE requires.
  - Reversal applies to every code. Callers feed extra bits pre-reversed.
- Undefined: codes are inserted exactly as given, LSB-first, and the reverser logic is absent.

## Structure
- Shared package `deflate_pkg` holds:
  - constants `MAX_CODE_LEN`, `ACC_W`, `LEN_W`;
  - an FSM state typedef with values RUN, FLUSH, DONE.
- One sub-module, `code_bit_reverser`: combinational reversal of a `MAX_CODE_LEN`-bit code over its low `in_len` bits. It is instantiated only under the macro.

## Test plan
- Basic packing, macro off:
  - Stimulus: code `0b101` len 3, then `0b11111` len 5, with `out_ready=1`.
  - Response: one byte `0xFD`, `byte_count=1`, no `flush_done`.
- Flush pad:
  - Stimulus: code `0b101` len 3, then `flush_req`.
  - Response: byte `0x05`, `flush_done` pulses one cycle after the handshake, `in_ready` is 0 during FLUSH and DONE, `fill=0` afterwards.
- Backpressure:
  - Stimulus: `out_ready=0`, continuous `0xFFFF` len 16.
  - Response: exactly two accepts (`fill=32`), then `in_ready=0`. Releasing `out_ready` yields four `0xFF` bytes.
- Error, macro off:
  - Stimulus: `in_len=20`, code `0x1FFFF`.
  - Response: 16 bits packed (`0xFF`, `0xFF`), `err_len` stays 1 until reset.
- Reverse, macro on:
  - Stimulus: code `0b110` len 3, then `0b00000` len 5.
  - Response: byte `0x03`.
- Reset mid-flush:
  - Stimulus: assert `reset` while `out_valid=1` in FLUSH.
  - Response: all outputs return to reset values, no `flush_done`, `byte_count=0`.

Source files
------------

// File: rtl/deflate_pkg.sv
// Shared constants, FSM state type and helpers for the DEFLATE bit packer.
package deflate_pkg;

  localparam int unsigned MAX_CODE_LEN = 16;
  localparam int unsigned ACC_W        = 32;
  localparam int unsigned LEN_W        = 5;
  localparam int unsigned FILL_W       = $clog2(ACC_W + 1);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    FLUSH = 2'd1,
    DONE  = 2'd2
  } state_e;

  typedef struct packed {
    logic [LEN_W-1:0]        len;
    logic [MAX_CODE_LEN-1:0] code;
  } code_word_t;

  // Ones in the low `len` bit positions; len is expected to be <= MAX_CODE_LEN.
  function automatic logic [MAX_CODE_LEN-1:0] len_mask(input logic [LEN_W-1:0] len);
    logic [MAX_CODE_LEN-1:0] m;
    for (int i = 0; i < MAX_CODE_LEN; i++) begin
      m[i] = (LEN_W'(i) < len);
    end
    return m;
  endfunction

endpackage

// File: rtl/code_bit_reverser.sv
// Reverses the low `len` bits of a code so MSB-first Huffman codes enter the stream first.
// Present only when DEFLATE_BIT_PACKER_REVERSE_EN is defined.
`ifdef DEFLATE_BIT_PACKER_REVERSE_EN
module code_bit_reverser
  import deflate_pkg::*;
(
  input  logic [MAX_CODE_LEN-1:0] code,
  input  logic [LEN_W-1:0]        len,
  output logic [MAX_CODE_LEN-1:0] rev_c
);

  logic [MAX_CODE_LEN-1:0] full_rev;

  // Reverse the whole word, then slide the reversed field down to bit 0.
  // Expects `code` already masked to `len` bits and len <= MAX_CODE_LEN.
  always_comb begin
    full_rev = '0;
    for (int i = 0; i < MAX_CODE_LEN; i++) begin
      full_rev[i] = code[MAX_CODE_LEN-1-i];
    end
    rev_c = full_rev >> (LEN_W'(MAX_CODE_LEN) - len);
  end

endmodule
`endif

// File: rtl/deflate_bit_packer.sv
// Packs variable-length codes LSB-first into a byte stream with pad-and-drain flush.
// Define DEFLATE_BIT_PACKER_REVERSE_EN to bit-reverse each code before insertion.
module deflate_bit_packer
  import deflate_pkg::*;
(
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [MAX_CODE_LEN-1:0] in_code,
  input  logic [LEN_W-1:0]        in_len,
  input  logic                    flush_req,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [7:0]              out_byte,
  output logic                    flush_done,
  output logic                    err_len,
  output logic [31:0]             byte_count
);

  localparam int unsigned BYTE_W    = 8;
  localparam int unsigned READY_MAX = ACC_W - MAX_CODE_LEN;

  state_e                  state_q, state_d;
  logic [ACC_W-1:0]        acc_q, acc_d, acc_e;
  logic [FILL_W-1:0]       fill_q, fill_d, fill_e;
  logic                    in_ready_d, out_valid_d, flush_done_d, err_len_d;
  logic [31:0]             byte_count_d;
  logic                    accept_c, emit_c, len_over_c;
  code_word_t              word_c;
  logic [MAX_CODE_LEN-1:0] ins_code_c;

  // Clamp oversize lengths and drop code bits above the length.
  always_comb begin
    len_over_c  = (in_len > LEN_W'(MAX_CODE_LEN));
    word_c.len  = len_over_c ? LEN_W'(MAX_CODE_LEN) : in_len;
    word_c.code = in_code & len_mask(word_c.len);
  end

`ifdef DEFLATE_BIT_PACKER_REVERSE_EN
  code_bit_reverser u_rev (
    .code  (word_c.code),
    .len   (word_c.len),
    .rev_c (ins_code_c)
  );
`else
  assign ins_code_c = word_c.code;
`endif

  assign out_byte = acc_q[7:0];

  // Next state: emit shift first, then insert at the reduced fill.
  // Handshake outputs are registered from the next-state values.
  always_comb begin
    state_d      = state_q;
    acc_e        = acc_q;
    fill_e       = fill_q;
    acc_d        = acc_q;
    fill_d       = fill_q;
    accept_c     = in_valid && in_ready;
    emit_c       = out_valid && out_ready;
    err_len_d    = err_len;
    byte_count_d = byte_count;

    if (emit_c) begin
      acc_e        = acc_q >> BYTE_W;
      fill_e       = (fill_q >= FILL_W'(BYTE_W)) ? fill_q - FILL_W'(BYTE_W) : '0;
      byte_count_d = byte_count + 32'd1;
    end

    acc_d  = acc_e;
    fill_d = fill_e;
    if (accept_c) begin
      acc_d     = acc_e | (ACC_W'(ins_code_c) << fill_e);
      fill_d    = fill_e + FILL_W'(word_c.len);
      err_len_d = err_len | len_over_c;
    end

    case (state_q)
      RUN:     if (flush_req) state_d = FLUSH;
      FLUSH:   if (fill_e == '0) state_d = DONE;
      DONE:    state_d = RUN;
      default: state_d = RUN;
    endcase

    in_ready_d   = (state_d == RUN) && (fill_d <= FILL_W'(READY_MAX));
    out_valid_d  = (fill_d >= FILL_W'(BYTE_W)) || ((state_d == FLUSH) && (fill_d != '0));
    flush_done_d = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= RUN;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc_q      <= '0;
      fill_q     <= '0;
      in_ready   <= 1'b1;
      out_valid  <= 1'b0;
      flush_done <= 1'b0;
      err_len    <= 1'b0;
      byte_count <= '0;
    end else begin
      acc_q      <= acc_d;
      fill_q     <= fill_d;
      in_ready   <= in_ready_d;
      out_valid  <= out_valid_d;
      flush_done <= flush_done_d;
      err_len    <= err_len_d;
      byte_count <= byte_count_d;
    end
  end

endmodule
